// File: rtl/nios2_oci_pkg.sv
// Shared types and constants for the OCI memory sequencer: FSM state
// encoding, JTAG data-out field positions and the fixed byte-enable.
package nios2_oci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  localparam int JDO_DATA_MSB    = 31;
  localparam int JDO_RDAFTERLOAD = 34;

  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/nios2_oci_watchdog.sv
// Stall watchdog: counts stalled cycles of one bus access and flags the
// cycle in which the LIMIT-th consecutive stall is seen.
module nios2_oci_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q;

  // Flag in the same cycle as the final stall so the owner can abort at
  // exactly LIMIT stalled cycles.
  assign expired = stall && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous because the whole block lives after the sysclk synchroniser.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (stall && !expired) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/nios2_oci_mem_sequencer.sv
// Turns JTAG debug memory commands into single-word Avalon-MM accesses and
// returns read data, ready and error status to the JTAG debug module.
module nios2_oci_mem_sequencer
  import nios2_oci_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         mon_q;
  logic [31:0]         wdata_q;
  logic                read_q;
  logic                write_q;
  logic                ready_q;
  logic                error_q;
  logic                wd_expired;
  logic                any_cmd;
  logic                unused_jdo_bits;

  assign any_cmd         = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[33:32]};

  nios2_oci_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .stall   ((state_q != IDLE) && avm_waitrequest),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Priority a > b > no_action; losing pulses vanish without error.
          if (take_action_ocimem_a) begin
            addr_q  <= {jdo[ADDR_W-1:2], 2'b00};
            error_q <= 1'b0;
            if (jdo[JDO_RDAFTERLOAD]) begin
              read_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= RD;
            end
          end else if (take_action_ocimem_b) begin
            wdata_q <= jdo[JDO_DATA_MSB:0];
            write_q <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            state_q <= WR;
          end else if (take_no_action_ocimem_a) begin
            read_q  <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            state_q <= RD;
          end
        end

        RD, WR: begin
          // A host command arriving mid-access is dropped but remembered.
          if (any_cmd) begin
            error_q <= 1'b1;
          end
          if (!avm_waitrequest) begin
            if (state_q == RD) begin
              mon_q <= avm_readdata;
            end
            addr_q  <= addr_q + ADDR_W'(4);
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (wd_expired) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = BYTEENABLE_ALL;

endmodule
